// File: rtl/controle_clock_pkg.sv
// Shared types and defaults for the clock-enable scheduler.
package controle_clock_pkg;

    localparam int DIV_WIDTH = 26;
    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = 26'd50;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

endpackage

// File: rtl/controle_clock_if.sv
// Control/status bundle between the board/core side and the tick scheduler.
interface controle_clock_if
    import controle_clock_pkg::*;
#(
    parameter int WIDTH = controle_clock_pkg::DIV_WIDTH
) ();

    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             cpu_halt;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             tick;
    logic             running;
    logic [WIDTH-1:0] div_cur;

    modport master (
        output run_req, step_req, halt_req, cpu_halt, div_load, div_value,
        input  tick, running, div_cur
    );

    modport slave (
        input  run_req, step_req, halt_req, cpu_halt, div_load, div_value,
        output tick, running, div_cur
    );

endinterface

// File: rtl/controle_clock_contador_tick.sv
// Period counter: counts 0..div and flags terminal count; equality compare means it never wraps.
module contador_tick
    import controle_clock_pkg::*;
#(
    parameter int DIV_WIDTH = controle_clock_pkg::DIV_WIDTH
) (
    input  logic                 f_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 terminal,
    output logic [DIV_WIDTH-1:0] count
);

    localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    assign terminal = enable && (count == div);

    always_ff @(posedge f_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (terminal) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/controle_clock.sv
// Clock-enable scheduler: HALT/RUN/STEP sequencing of a programmable-period tick pulse.
//   state   | meaning
//   ST_HALT | counter held at 0, no ticks, divisor may be reloaded
//   ST_RUN  | tick every div+1 cycles until halted
//   ST_STEP | one tick at terminal count, then back to HALT
module controle_clock
    import controle_clock_pkg::*;
#(
    parameter int                   DIV_WIDTH   = controle_clock_pkg::DIV_WIDTH,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = controle_clock_pkg::DEFAULT_DIV
) (
    input  logic            f_in,
    input  logic            reset,
    controle_clock_if.slave bus
);

    state_t               state;
    logic                 run_q;
    logic                 step_q;
    logic                 tick_q;
    logic                 running_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] count;
    logic                 terminal;
    logic                 halt_any;
    logic                 run_edge;
    logic                 step_edge;
    logic                 cnt_enable;
    logic                 cnt_clear;

    assign halt_any   = bus.halt_req | bus.cpu_halt;
    assign run_edge   = bus.run_req & ~run_q;
    assign step_edge  = bus.step_req & ~step_q;
    assign cnt_enable = (state == ST_RUN) || (state == ST_STEP);
    // A halt clears the count in the same edge it takes effect, so a restart always begins at 0.
    assign cnt_clear  = halt_any || !cnt_enable;

    contador_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_contador (
        .f_in     (f_in),
        .reset    (reset),
        .enable   (cnt_enable),
        .clear    (cnt_clear),
        .div      (div_q),
        .terminal (terminal),
        .count    (count)
    );

    always_ff @(posedge f_in or posedge reset) begin
        if (reset) begin
            state     <= ST_HALT;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            div_q     <= DEFAULT_DIV;
        end else begin
            run_q  <= bus.run_req;
            step_q <= bus.step_req;
            tick_q <= 1'b0;
            if (state == ST_HALT && bus.div_load) begin
                div_q <= bus.div_value;
            end
            if (halt_any) begin
                state     <= ST_HALT;
                running_q <= 1'b0;
            end else begin
                case (state)
                    ST_HALT: begin
                        if (run_edge) begin
                            state     <= ST_RUN;
                            running_q <= 1'b1;
                        end else if (step_edge) begin
                            state     <= ST_STEP;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (terminal) begin
                            tick_q <= 1'b1;
                        end
                    end
                    ST_STEP: begin
                        if (terminal) begin
                            tick_q    <= 1'b1;
                            state     <= ST_HALT;
                            running_q <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_HALT;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.div_cur = div_q;

endmodule

// File: tb/tb_controle_clock.sv
// Directed bench for controle_clock: expected tick cycles are queued by stimulus and checked by a monitor.
module tb_controle_clock;
    import controle_clock_pkg::*;

    logic f_in;
    logic reset;
    int   cyc;
    int   exp_q[$];
    int   n_checks;
    int   n_fail;
    int   e_cyc;
    int   n, s, r, a, b;

    controle_clock_if bus ();

    controle_clock dut (
        .f_in  (f_in),
        .reset (reset),
        .bus   (bus)
    );

    initial f_in = 1'b0;
    always #10 f_in = ~f_in;

    initial cyc = 0;
    always @(posedge f_in) cyc = cyc + 1;

    // Monitor: every tick seen must match the oldest expected tick cycle.
    always @(negedge f_in) begin
        if (bus.tick === 1'b1) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_tick: tick seen at cycle %0d, required none", cyc);
            end else begin
                e_cyc = exp_q.pop_front();
                if (e_cyc != cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL tick_cycle: tick at cycle %0d, required cycle %0d", cyc, e_cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge f_in);
        #2;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) next_cycle();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.run_req   = 1'b0;
        bus.step_req  = 1'b0;
        bus.halt_req  = 1'b0;
        bus.cpu_halt  = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        repeat (3) @(posedge f_in);
        #2;
        check("reset_tick", {31'd0, bus.tick}, 32'd0);
        check("reset_running", {31'd0, bus.running}, 32'd0);
        check("reset_div_cur", {6'd0, bus.div_cur}, 32'd50);
        reset = 1'b0;
        next_cycle();

        // RUN with default divisor, then halt between ticks
        next_cycle();
        bus.run_req = 1'b1;
        n = cyc;
        exp_q.push_back(n + 52);
        exp_q.push_back(n + 103);
        exp_q.push_back(n + 154);
        next_cycle();
        bus.run_req = 1'b0;
        check("run_running", {31'd0, bus.running}, 32'd1);
        step_to(n + 160);
        bus.halt_req = 1'b1;
        next_cycle();
        bus.halt_req = 1'b0;
        check("halt_running", {31'd0, bus.running}, 32'd0);
        step_to(n + 215);

        // Load div=3 in HALT, single step
        next_cycle();
        bus.div_load  = 1'b1;
        bus.div_value = 26'd3;
        next_cycle();
        bus.div_load = 1'b0;
        check("load_div_cur", {6'd0, bus.div_cur}, 32'd3);
        next_cycle();
        bus.step_req = 1'b1;
        s = cyc;
        exp_q.push_back(s + 5);
        next_cycle();
        bus.step_req = 1'b0;
        check("step_running_start", {31'd0, bus.running}, 32'd1);
        step_to(s + 4);
        check("step_running_before_tick", {31'd0, bus.running}, 32'd1);
        step_to(s + 5);
        check("step_running_at_tick", {31'd0, bus.running}, 32'd0);
        step_to(s + 12);

        // RUN with div=3, ignored reload, halt at terminal count
        next_cycle();
        bus.run_req = 1'b1;
        r = cyc;
        exp_q.push_back(r + 5);
        exp_q.push_back(r + 9);
        exp_q.push_back(r + 13);
        next_cycle();
        bus.run_req = 1'b0;
        step_to(r + 2);
        bus.div_load  = 1'b1;
        bus.div_value = 26'd7;
        next_cycle();
        bus.div_load = 1'b0;
        check("run_load_ignored", {6'd0, bus.div_cur}, 32'd3);
        step_to(r + 16);
        check("count_at_terminal", {6'd0, dut.count}, 32'd3);
        bus.halt_req = 1'b1;
        next_cycle();
        bus.halt_req = 1'b0;
        check("halt_tc_running", {31'd0, bus.running}, 32'd0);
        check("halt_tc_count", {6'd0, dut.count}, 32'd0);
        next_cycle();
        check("halt_count_held", {6'd0, dut.count}, 32'd0);
        step_to(r + 26);

        // Run and step edges together: run wins; held step does not retrigger; cpu_halt stops
        next_cycle();
        bus.run_req  = 1'b1;
        bus.step_req = 1'b1;
        a = cyc;
        exp_q.push_back(a + 5);
        exp_q.push_back(a + 9);
        exp_q.push_back(a + 13);
        next_cycle();
        bus.run_req = 1'b0;
        step_to(a + 10);
        check("both_edges_run", {31'd0, bus.running}, 32'd1);
        step_to(a + 14);
        bus.cpu_halt = 1'b1;
        next_cycle();
        bus.cpu_halt = 1'b0;
        check("cpu_halt_running", {31'd0, bus.running}, 32'd0);
        step_to(a + 30);
        check("held_step_no_restart", {31'd0, bus.running}, 32'd0);
        bus.step_req = 1'b0;
        next_cycle();

        // Reset in the middle of a step with div=5
        next_cycle();
        bus.div_load  = 1'b1;
        bus.div_value = 26'd5;
        next_cycle();
        bus.div_load = 1'b0;
        check("load_div5", {6'd0, bus.div_cur}, 32'd5);
        next_cycle();
        bus.step_req = 1'b1;
        b = cyc;
        next_cycle();
        bus.step_req = 1'b0;
        step_to(b + 3);
        check("step_count_before_reset", {6'd0, dut.count}, 32'd2);
        reset = 1'b1;
        #1;
        check("async_reset_tick", {31'd0, bus.tick}, 32'd0);
        check("async_reset_running", {31'd0, bus.running}, 32'd0);
        check("async_reset_div_cur", {6'd0, bus.div_cur}, 32'd50);
        next_cycle();
        reset = 1'b0;
        step_to(b + 80);
        check("post_reset_running", {31'd0, bus.running}, 32'd0);
        check("pending_ticks", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
